// File: rtl/music_pkg.sv
// Shared state encodings, default timing constants and track-step helper for music_ctrl.
package music_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_SWITCH = 2'd3
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 2_000_000;
    localparam int DEF_TICK_CYCLES     = 100_000_000;
    localparam int DEF_TRACK_SEC       = 60;
    localparam int DEF_RST_HOLD        = 1000;
    localparam int DEF_NUM_TRACKS      = 8;

    // Wrapping step through 0..num-1 in either direction.
    function automatic logic [2:0] track_step(input logic [2:0] id, input logic down, input int num);
        if (down)
            return (id == 3'd0) ? 3'(num - 1) : id - 3'd1;
        else
            return (int'(id) == num - 1) ? 3'd0 : id + 3'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchroniser + debouncer + rising-edge pulse; pulse 2+DEBOUNCE_CYCLES cycles after a stable press.
// No backpressure: one pulse per accepted press, holding produces no further pulses.
module btn_debounce
    import music_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_d <= level;
            // Any sample matching the accepted level restarts the stability count.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign pulse = level & ~level_d;

endmodule

// File: rtl/music_ctrl.sv
// Music player controller: debounced buttons drive IDLE/PLAY/PAUSE/SWITCH, track select and elapsed seconds.
// Button to state change is 3+DEBOUNCE_CYCLES cycles; no backpressure, presses during SWITCH are dropped.
module music_ctrl
    import music_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TICK_CYCLES     = DEF_TICK_CYCLES,
    parameter int TRACK_SEC       = DEF_TRACK_SEC,
    parameter int RST_HOLD        = DEF_RST_HOLD,
    parameter int NUM_TRACKS      = DEF_NUM_TRACKS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_play,
    input  logic       btn_next,
    input  logic       btn_prev,
    output logic [2:0] music_id,
    output logic       start,
    output logic       player_rst,
    output logic [7:0] elapsed,
    output logic       playing
);

    localparam int TW = $clog2(TICK_CYCLES + 1);
    localparam int HW = $clog2(RST_HOLD + 1);

    state_t        state;
    state_t        next_state;
    state_t        ret_state;
    logic [TW-1:0] tick;
    logic [HW-1:0] hold_cnt;
    logic          play_p;
    logic          next_p;
    logic          prev_p;
    logic          nav;
    logic          play_only;
    logic          sec_wrap;
    logic          auto_adv;
    logic          go_switch;
    logic          go_down;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_play (
        .clk(clk), .rst(rst), .btn(btn_play), .pulse(play_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk(clk), .rst(rst), .btn(btn_next), .pulse(next_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
        .clk(clk), .rst(rst), .btn(btn_prev), .pulse(prev_p)
    );

    // Simultaneous next+prev cancel; play coinciding with either is dropped.
    assign nav       = next_p ^ prev_p;
    assign play_only = play_p & ~next_p & ~prev_p;
    assign sec_wrap  = (state == ST_PLAY) && (tick == TW'(TICK_CYCLES - 1));
    assign auto_adv  = sec_wrap && (elapsed == 8'(TRACK_SEC - 1));

    always_comb begin
        next_state = state;
        go_switch  = 1'b0;
        go_down    = nav & prev_p;
        case (state)
            ST_IDLE: begin
                if (play_only) next_state = ST_PLAY;
            end
            ST_PLAY: begin
                if (nav || auto_adv) begin
                    go_switch  = 1'b1;
                    next_state = ST_SWITCH;
                end else if (play_only) begin
                    next_state = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (nav) begin
                    go_switch  = 1'b1;
                    next_state = ST_SWITCH;
                end else if (play_only) begin
                    next_state = ST_PLAY;
                end
            end
            ST_SWITCH: begin
                if (hold_cnt == HW'(RST_HOLD - 1)) next_state = ret_state;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            ret_state  <= ST_IDLE;
            music_id   <= 3'd0;
            player_rst <= 1'b0;
            hold_cnt   <= '0;
            tick       <= '0;
            elapsed    <= 8'd0;
        end else begin
            state <= next_state;
            // Registered from next_state so the low window lines up exactly with SWITCH.
            player_rst <= (next_state != ST_SWITCH);

            if (state == ST_SWITCH) hold_cnt <= hold_cnt + HW'(1);
            else                    hold_cnt <= '0;

            if (go_switch) begin
                ret_state <= state;
                music_id  <= track_step(music_id, go_down, NUM_TRACKS);
                tick      <= '0;
                elapsed   <= 8'd0;
            end else if (state == ST_PLAY) begin
                if (sec_wrap) begin
                    tick    <= '0;
                    elapsed <= elapsed + 8'd1;
                end else begin
                    tick <= tick + TW'(1);
                end
            end
        end
    end

    assign start   = (state == ST_PLAY);
    assign playing = (state == ST_PLAY);

endmodule

// File: tb/tb_music_ctrl.sv
// Directed bench for music_ctrl with short timing parameters; rows give buttons, cycles to run, expected outputs.
module tb_music_ctrl;

    localparam logic [2:0] B0 = 3'b000;
    localparam logic [2:0] BP = 3'b100;
    localparam logic [2:0] BN = 3'b010;
    localparam logic [2:0] BV = 3'b001;

    typedef struct {
        logic [2:0] btn;
        int         n;
        logic [2:0] mid;
        logic       st;
        logic       pl;
        logic       prst;
        logic [7:0] el;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       btn_play;
    logic       btn_next;
    logic       btn_prev;
    logic [2:0] music_id;
    logic       start;
    logic       player_rst;
    logic [7:0] elapsed;
    logic       playing;

    int   checks   = 0;
    int   failures = 0;
    vec_t tbl[$];
    int   split_idx;

    music_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .TICK_CYCLES    (10),
        .TRACK_SEC      (3),
        .RST_HOLD       (5),
        .NUM_TRACKS     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_play  (btn_play),
        .btn_next  (btn_next),
        .btn_prev  (btn_prev),
        .music_id  (music_id),
        .start     (start),
        .player_rst(player_rst),
        .elapsed   (elapsed),
        .playing   (playing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic [2:0] b, input int n, input logic [2:0] m,
                       input logic s, input logic p, input logic r, input logic [7:0] e);
        vec_t v;
        v.btn = b; v.n = n; v.mid = m; v.st = s; v.pl = p; v.prst = r; v.el = e;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %0h expected %0h at t=%0t", nm, idx, act, exp, $time);
        end
    endtask

    task automatic chk_all(input int idx, input logic [2:0] m, input logic s, input logic p,
                           input logic r, input logic [7:0] e);
        chk("music_id",   idx, 8'(music_id),   8'(m));
        chk("start",      idx, 8'(start),      8'(s));
        chk("playing",    idx, 8'(playing),    8'(p));
        chk("player_rst", idx, 8'(player_rst), 8'(r));
        chk("elapsed",    idx, elapsed,        e);
    endtask

    task automatic apply(input int i);
        {btn_play, btn_next, btn_prev} = tbl[i].btn;
        repeat (tbl[i].n) @(posedge clk);
        #1;
        chk_all(i, tbl[i].mid, tbl[i].st, tbl[i].pl, tbl[i].prst, tbl[i].el);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        // Playback, pause/freeze, auto-advance and switch return paths.
        add(BP, 6,  0, 0, 0, 1, 0);
        add(BP, 1,  0, 1, 1, 1, 0);
        add(BP, 3,  0, 1, 1, 1, 0);
        add(B0, 15, 0, 1, 1, 1, 1);
        add(B0, 7,  0, 1, 1, 1, 2);
        add(B0, 5,  1, 0, 0, 0, 0);
        add(B0, 4,  1, 0, 0, 0, 0);
        add(B0, 1,  1, 1, 1, 1, 0);
        add(B0, 12, 1, 1, 1, 1, 1);
        add(BP, 7,  1, 0, 0, 1, 1);
        add(BP, 3,  1, 0, 0, 1, 1);
        add(B0, 20, 1, 0, 0, 1, 1);
        add(BN, 7,  2, 0, 0, 0, 0);
        add(BN, 3,  2, 0, 0, 0, 0);
        add(B0, 2,  2, 0, 0, 1, 0);
        add(B0, 10, 2, 0, 0, 1, 0);
        add(BN, 50, 3, 0, 0, 1, 0);
        add(B0, 10, 3, 0, 0, 1, 0);
        for (int k = 4; k <= 7; k++) begin
            add(BN, 10, 3'(k), 0, 0, 0, 0);
            add(B0, 10, 3'(k), 0, 0, 1, 0);
        end
        add(BN, 10, 0, 0, 0, 0, 0);
        add(B0, 10, 0, 0, 0, 1, 0);
        add(BV, 10, 7, 0, 0, 0, 0);
        add(B0, 10, 7, 0, 0, 1, 0);
        add(BN | BV, 10, 7, 0, 0, 1, 0);
        add(B0, 10, 7, 0, 0, 1, 0);
        add(BP | BN, 10, 0, 0, 0, 0, 0);
        add(B0, 10, 0, 0, 0, 1, 0);
        add(BV, 2,  0, 0, 0, 1, 0);
        add(BV | BN, 8, 7, 0, 0, 0, 0);
        add(B0, 20, 7, 0, 0, 1, 0);
        add(BP, 3,  7, 0, 0, 1, 0);
        add(B0, 15, 7, 0, 0, 1, 0);
        add(BP, 4,  7, 0, 0, 1, 0);
        add(B0, 4,  7, 1, 1, 1, 0);
        add(B0, 10, 7, 1, 1, 1, 1);
        add(BV, 8,  6, 0, 0, 0, 0);
        split_idx = tbl.size();
        // After reset: IDLE must ignore navigation, then accept play.
        add(BN, 10, 0, 0, 0, 1, 0);
        add(B0, 10, 0, 0, 0, 1, 0);
        add(BV, 10, 0, 0, 0, 1, 0);
        add(B0, 10, 0, 0, 0, 1, 0);
        add(BP, 7,  0, 1, 1, 1, 0);

        rst = 1'b0;
        {btn_play, btn_next, btn_prev} = B0;
        repeat (3) @(posedge clk);
        #1;
        chk_all(-1, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_all(-2, 0, 0, 0, 1, 0);

        for (int i = 0; i < split_idx; i++) apply(i);

        // Asynchronous reset in the middle of SWITCH.
        #3;
        rst = 1'b0;
        #1;
        chk_all(-3, 0, 0, 0, 0, 0);
        {btn_play, btn_next, btn_prev} = B0;
        repeat (3) @(posedge clk);
        #1;
        chk_all(-4, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_all(-5, 0, 0, 0, 1, 0);

        for (int i = split_idx; i < tbl.size(); i++) apply(i);

        // Asynchronous reset in the middle of PLAY.
        #3;
        rst = 1'b0;
        #1;
        chk_all(-6, 0, 0, 0, 0, 0);
        {btn_play, btn_next, btn_prev} = B0;
        repeat (2) @(posedge clk);
        #1;
        chk_all(-7, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/music_ctrl.md
MUSIC_CTRL -- requirements
Module: music_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 2_000_000: cycles a synchronised button level must stay stable before it is accepted (20 ms at 100 MHz).
REQ-002 SHALL have parameter TICK_CYCLES, default 100_000_000: clk cycles per elapsed-time second.
REQ-003 SHALL have parameter TRACK_SEC, default 60: seconds per track before auto-advance.
REQ-004 SHALL have parameter RST_HOLD, default 1000: cycles player_rst is held low on a track change.
REQ-005 SHALL have parameter NUM_TRACKS, default 8: track count, at most 8.
REQ-006 SHALL have port clk, input, 1 bit: system clock, 100 MHz.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port btn_play, input, 1 bit: raw play/pause button, active-high, asynchronous to clk.
REQ-009 SHALL have port btn_next, input, 1 bit: raw next-track button, active-high, asynchronous to clk.
REQ-010 SHALL have port btn_prev, input, 1 bit: raw previous-track button, active-high, asynchronous to clk.
REQ-011 SHALL have port music_id, output, 3 bits: selected track, driving the player's ROM bank select.
REQ-012 SHALL have port start, output, 1 bit: player enable; player streams only while high.
REQ-013 SHALL have port player_rst, output, 1 bit: active-low reset to the SPI player, restarting the current track.
REQ-014 SHALL have port elapsed, output, 8 bits: seconds played in the current track.
REQ-015 SHALL have port playing, output, 1 bit: high exactly in state PLAY, for LED.

Function
REQ-016 SHALL pass each button through a 2-FF synchroniser, then a debouncer; the debounced level SHALL update only after DEBOUNCE_CYCLES consecutive identical samples.
REQ-017 SHALL generate a 1-cycle press pulse on each debounced rising edge; holding a button SHALL produce one pulse only.
REQ-018 SHALL implement states IDLE, PLAY, PAUSE, SWITCH.
REQ-019 IDLE: play pulse -> PLAY.
REQ-020 PLAY: play pulse -> PAUSE; next/prev pulse or auto-advance -> SWITCH.
REQ-021 PAUSE: play pulse -> PLAY; next/prev pulse -> SWITCH.
REQ-022 SWITCH: player_rst = 0 for exactly RST_HOLD cycles, then return to the state that entered SWITCH (PLAY or PAUSE; IDLE is never a source).
REQ-023 SHALL ignore all press pulses while in SWITCH and while in IDLE, except a play pulse in IDLE.
REQ-024 SHALL drive start = 1 in PLAY only, and 0 in IDLE, PAUSE and SWITCH.
REQ-025 On entry to SWITCH via next or auto-advance, music_id SHALL become (music_id+1) mod NUM_TRACKS, with wrap NUM_TRACKS-1 -> 0.
REQ-026 On entry to SWITCH via prev, music_id SHALL become music_id-1, with wrap 0 -> NUM_TRACKS-1.
REQ-027 music_id SHALL update in the same cycle SWITCH is entered.
REQ-028 next and prev pulses in the same cycle SHALL cancel: no switch occurs.
REQ-029 A play pulse in the same cycle as next or prev SHALL be ignored; the switch wins.
REQ-030 In PLAY, a tick counter SHALL count 0..TICK_CYCLES-1 and wrap; each wrap SHALL increment elapsed.
REQ-031 The tick counter and elapsed SHALL freeze in PAUSE and SWITCH.
REQ-032 When elapsed would reach TRACK_SEC, elapsed SHALL instead clear to 0 and auto-advance SHALL occur in that cycle.
REQ-033 Any SWITCH entry SHALL clear elapsed and the tick counter to 0.

Reset
REQ-034 rst low SHALL asynchronously force: state IDLE, music_id 0, start 0, player_rst 0, elapsed 0, playing 0, tick counter 0, debounce levels 0, synchronisers 0.
REQ-035 After rst releases, player_rst SHALL go high on the first clk edge.
REQ-036 A reset asserted mid-SWITCH or mid-PLAY SHALL abort the operation with no residual pulses.

Structure
REQ-037 State encodings and default parameter constants SHALL reside in shared package music_pkg.
REQ-038 SHALL instantiate sub-module btn_debounce (synchroniser, debouncer and edge pulse) three times, once per button.

Verification (DEBOUNCE_CYCLES=4, TICK_CYCLES=10, TRACK_SEC=3, RST_HOLD=5)
REQ-039 Reset, then press play for 10 cycles -> start=1 and playing=1 about 7 cycles after press; music_id=0.
REQ-040 Play 25 cycles -> elapsed=2. Play 10 more -> auto-advance: music_id=1, player_rst low 5 cycles, elapsed=0, then PLAY resumes.
REQ-041 At music_id=7, press next -> music_id=0. At music_id=0, press prev -> music_id=7. Hold next 50 cycles -> exactly one increment.
REQ-042 PLAY then play press -> start=0 and elapsed frozen. Press next while in PAUSE -> SWITCH, then back to PAUSE with start=0.
REQ-043 next and prev pulses in the same cycle -> no change. Next pressed during SWITCH -> ignored.
REQ-044 Button bounce shorter than 4 cycles -> no pulse. rst asserted mid-SWITCH -> all outputs at reset values immediately.
